vga_sync_monitor: RTL and testbench

//  Receive-side counterpart of the VGA 640x480 timing generator. Samples

---
 rtl/vga_sync_monitor.sv | 202 ++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates from sampled
// hsync/vsync, measures line/frame periods and declares lock after good frames.
module vga_sync_monitor #(
  parameter int H_TOTAL      = 800,
  parameter int V_TOTAL      = 525,
  parameter int H_DISP       = 640,
  parameter int V_DISP       = 480,
  parameter int H_SYNC_START = 656,
  parameter int V_SYNC_START = 513,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        video_on,
  output logic        frame_start,
  output logic [10:0] line_period,
  output logic [10:0] frame_lines,
  output logic        locked,
  output logic        sync_err
);

  localparam logic [10:0] H_TOTAL_C = 11'(H_TOTAL);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] TIMEOUT_C = 11'(2 * H_TOTAL);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HSS_C     = 10'(H_SYNC_START);
  localparam logic [9:0]  VSS_C     = 10'(V_SYNC_START);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        first_h_q, first_h_d;
  logic [10:0] hp_cnt_q, hp_cnt_d;
  logic [10:0] vl_cnt_q, vl_cnt_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;
  logic [10:0] line_period_q, line_period_d;
  logic [10:0] frame_lines_q, frame_lines_d;
  logic        locked_q, locked_d;
  logic        frame_start_q, frame_start_d;
  logic        sync_err_q, sync_err_d;

  logic        hs_fall, vs_fall, timeout, line_err, frame_err, any_err;
  logic [10:0] hp_inc;
  logic [3:0]  good_inc;

  assign hs_fall   = p_tick & hs_prev_q & ~hsync;
  assign vs_fall   = p_tick & vs_prev_q & ~vsync;
  assign hp_inc    = sat_inc(hp_cnt_q);
  assign good_inc  = good_q + 4'd1;
  // A falling hsync restarts the line counter, so it can never time out itself.
  assign timeout   = p_tick & ~hs_fall & (hp_inc == TIMEOUT_C);
  assign line_err  = hs_fall & ~first_h_q & (hp_inc != H_TOTAL_C) & (state_q != SEARCH);
  assign frame_err = vs_fall & (vl_cnt_q != V_TOTAL_C) & (state_q != SEARCH);
  assign any_err   = line_err | frame_err;

  always_comb begin
    state_d       = state_q;
    good_d        = good_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    first_h_d     = first_h_q;
    hp_cnt_d      = hp_cnt_q;
    vl_cnt_d      = vl_cnt_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_period_d = line_period_q;
    frame_lines_d = frame_lines_q;
    locked_d      = locked_q;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;

    if (p_tick) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;

      if (hs_fall) begin
        line_period_d = hp_inc;
        hp_cnt_d      = '0;
        first_h_d     = 1'b0;
        vl_cnt_d      = sat_inc(vl_cnt_q);
        pixel_x_d     = HSS_C;
      end else begin
        hp_cnt_d = hp_inc;
        if (pixel_x_q == H_LAST) begin
          pixel_x_d = '0;
          pixel_y_d = (pixel_y_q == V_LAST) ? '0 : pixel_y_q + 10'd1;
        end else begin
          pixel_x_d = pixel_x_q + 10'd1;
        end
      end

      // vsync edge overrides both the line-wrap y increment and the line count.
      if (vs_fall) begin
        pixel_y_d     = VSS_C;
        frame_lines_d = vl_cnt_q;
        vl_cnt_d      = hs_fall ? 11'd1 : 11'd0;
        frame_start_d = 1'b1;
      end

      if (timeout) begin
        sync_err_d = 1'b1;
        state_d    = SEARCH;
        locked_d   = 1'b0;
        good_d     = '0;
        first_h_d  = 1'b1;
      end else begin
        case (state_q)
          SEARCH: begin
            if (vs_fall) begin
              state_d = VERIFY;
              good_d  = '0;
            end
          end
          VERIFY: begin
            if (any_err) begin
              sync_err_d = 1'b1;
              good_d     = '0;
            end else if (vs_fall) begin
              good_d = good_inc;
              if (good_inc == LOCK_C) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end
          end
          LOCKED: begin
            if (any_err) begin
              sync_err_d = 1'b1;
              locked_d   = 1'b0;
              state_d    = VERIFY;
              good_d     = '0;
            end
          end
          default: begin
            state_d  = SEARCH;
            locked_d = 1'b0;
            good_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      good_q        <= '0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      first_h_q     <= 1'b1;
      hp_cnt_q      <= '0;
      vl_cnt_q      <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_period_q <= '0;
      frame_lines_q <= '0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_q        <= good_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      first_h_q     <= first_h_d;
      hp_cnt_q      <= hp_cnt_d;
      vl_cnt_q      <= vl_cnt_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_period_q <= line_period_d;
      frame_lines_q <= frame_lines_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_period = line_period_q;
  assign frame_lines = frame_lines_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign sync_err    = sync_err_q;
  assign video_on    = locked_q && (pixel_x_q < 10'(H_DISP)) && (pixel_y_q < 10'(V_DISP));

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor on a scaled 40x20 raster (sync at x=34..37, y=17..18);
// expected frame/error events are queued by the driver and matched by a monitor.
module tb_vga_sync_monitor;

  localparam int H_T = 40;
  localparam int V_T = 20;

  logic        clk, reset, p_tick, hsync, vsync;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_start, locked, sync_err;
  logic [10:0] line_period, frame_lines;

  vga_sync_monitor #(
    .H_TOTAL(H_T), .V_TOTAL(V_T), .H_DISP(32), .V_DISP(16),
    .H_SYNC_START(34), .V_SYNC_START(17), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .frame_start(frame_start), .line_period(line_period),
    .frame_lines(frame_lines), .locked(locked), .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int fs; int se; int lk; int lp; int fl; int vid; int per; int tk;
  } ev_t;

  ev_t sb[$];
  ev_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  tp = 4;
  int  tick_no = 0;
  int  cur_x = 0;
  int  cur_y = 0;
  bit  check_pix = 0;
  int  vid_cnt = 0;
  int  ticks_since = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic expect_ev(input int fs, se, lk, lp, fl, vid, per, tk);
    ev_t e;
    e.fs = fs; e.se = se; e.lk = lk; e.lp = lp; e.fl = fl;
    e.vid = vid; e.per = per; e.tk = tk;
    sb.push_back(e);
  endtask

  task automatic tick(input logic hs, input logic vs, input int x, input int y);
    @(negedge clk);
    p_tick = 1'b1; hsync = hs; vsync = vs; cur_x = x; cur_y = y;
    tick_no++;
    @(negedge clk);
    p_tick = 1'b0;
    repeat (tp - 2) @(negedge clk);
  endtask

  task automatic frame(input int nlines, input int short_y);
    int len;
    for (int y = 0; y < nlines; y++) begin
      len = (y == short_y) ? H_T - 1 : H_T;
      for (int x = 0; x < len; x++)
        tick(!(x >= 34 && x < 38), !(y >= 17 && y < 19), x, y);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 0, 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pixel_x"}, int'(pixel_x), 0);
    chk({tag, "_pixel_y"}, int'(pixel_y), 0);
    chk({tag, "_video_on"}, int'(video_on), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_line_period"}, int'(line_period), 0);
    chk({tag, "_frame_lines"}, int'(frame_lines), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      vid_cnt = 0;
      ticks_since = 0;
    end else begin
      if (p_tick) begin
        ticks_since++;
        if (video_on) vid_cnt++;
        if (check_pix) begin
          chk("pixel_x_track", int'(pixel_x), cur_x);
          chk("pixel_y_track", int'(pixel_y), cur_y);
        end
      end
      if (frame_start || sync_err) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("ev_frame_start", int'(frame_start), mon_e.fs);
          chk("ev_sync_err", int'(sync_err), mon_e.se);
          chk("ev_locked", int'(locked), mon_e.lk);
          chk("ev_line_period", int'(line_period), mon_e.lp);
          chk("ev_frame_lines", int'(frame_lines), mon_e.fl);
          if (mon_e.vid >= 0) chk("ev_video_ticks", vid_cnt, mon_e.vid);
          if (mon_e.per >= 0) chk("ev_frame_period", ticks_since, mon_e.per);
          if (mon_e.tk >= 0) chk("ev_tick_index", tick_no, mon_e.tk);
        end
        if (frame_start) begin
          vid_cnt = 0;
          ticks_since = 0;
        end
      end
    end
  end

  initial begin
    reset = 1'b1; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;

    // Nominal source, tick every 4 clocks: lock at the third vsync edge.
    expect_ev(1, 0, 0, 40, 17, 0, 681, -1); frame(V_T, -1);
    expect_ev(1, 0, 0, 40, 20, 0, 800, -1); frame(V_T, -1);
    expect_ev(1, 0, 1, 40, 20, 0, 800, -1); frame(V_T, -1);
    expect_ev(1, 0, 1, 40, 20, 512, 800, -1); frame(V_T, -1);

    // Locked coordinate tracking, tick every 2 clocks.
    tp = 2;
    check_pix = 1;
    expect_ev(1, 0, 1, 40, 20, 512, 800, -1); frame(V_T, -1);
    expect_ev(1, 0, 1, 40, 20, 512, 800, -1); frame(V_T, -1);
    check_pix = 0;

    // One 39-tick line, then relock after two good frames.
    expect_ev(0, 1, 0, 39, 20, -1, -1, -1);
    expect_ev(1, 0, 0, 40, 20, -1, 799, -1); frame(V_T, 5);
    expect_ev(1, 0, 1, 40, 20, 0, 800, -1); frame(V_T, -1);
    expect_ev(1, 0, 1, 40, 20, 512, 800, -1); frame(V_T, -1);

    // 19-line frame: caught at the following vsync edge.
    expect_ev(1, 0, 1, 40, 20, 512, 800, -1); frame(V_T - 1, -1);
    expect_ev(1, 1, 0, 40, 19, -1, 760, -1); frame(V_T, -1);

    // hsync stuck high: timeout 80 ticks after the last hsync edge.
    expect_ev(0, 1, 0, 40, 19, -1, -1, tick_no + 75);
    idle(100);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_video_on", int'(video_on), 0);

    expect_ev(1, 0, 0, 40, 20, 0, 900, -1); frame(V_T, -1);
    expect_ev(1, 0, 0, 40, 20, 0, 800, -1); frame(V_T, -1);
    expect_ev(1, 0, 1, 40, 20, 0, 800, -1); frame(V_T, -1);

    // Reset while locked, mid-frame, then full relock.
    frame(5, -1);
    chk("pre_reset_locked", int'(locked), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset("midrst");
    hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tp = 4;
    expect_ev(1, 0, 0, 40, 17, 0, 681, -1); frame(V_T, -1);
    expect_ev(1, 0, 0, 40, 20, 0, 800, -1); frame(V_T, -1);
    expect_ev(1, 0, 1, 40, 20, 0, 800, -1); frame(V_T, -1);

    repeat (4) @(negedge clk);
    chk("events_outstanding", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
